fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the decode/control block.
- Owns the 16-bit program counter and issues one request at a time to instruction memory.
- Presents each returned 32-bit instruction, with its PC, in an IF/ID output register that decode consumes.
- Handles decode back-pressure (stall) and taken-branch/jump redirects, including discarding a stale in-flight memory response.

Parameters:
PC_WIDTH, 16, program counter and instruction-address width (word-addressed; one instruction per address)
INSTR_WIDTH, 32, instruction word width
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  one-cycle request strobe to instruction memory
imem_addr  output  PC_WIDTH  fetch address; valid while imem_req=1
imem_valid  input  1  response strobe; imem_data is valid this cycle
imem_data  input  INSTR_WIDTH  returned instruction word
stall  input  1  decode cannot accept; hold the IF/ID register
redirect_valid  input  1  taken branch/jump; restart fetch at redirect_pc
redirect_pc  input  PC_WIDTH  redirect target address
if_valid  output  1  IF/ID register holds a valid instruction
if_instr  output  INSTR_WIDTH  fetched instruction
if_pc  output  PC_WIDTH  address of if_instr
if_pc_next  output  PC_WIDTH  if_pc+1, modulo 2^PC_WIDTH

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=ISSUE, if_valid=0, if_instr=0, if_pc=0, if_pc_next=0, hold buffer cleared. imem_req=0 while reset is high.
- States:
  - ISSUE: imem_req=1 and imem_addr=pc, unless redirect_valid=1 that cycle; redirect gates imem_req to 0 combinationally. Advance to WAIT when a request is issued.
  - WAIT: imem_req=0; one request outstanding. On imem_valid:
    - capture {imem_data, pc} and set pc<=pc+1;
    - if the slot is free this edge (if_valid=0, or stall=0), load the slot and go to ISSUE;
    - otherwise store the capture in the hold buffer and go to HOLD.
  - HOLD: imem_req=0. On the first edge with stall=0, the current slot is consumed; load the slot from the hold buffer and go to ISSUE.
  - DRAIN: imem_req=0. Discard the next imem_valid, then go to ISSUE.
- Slot consumption: on any edge with if_valid=1 and stall=0, decode takes the slot. if_valid becomes 0 unless a new load occurs at the same edge.
- Redirect has highest priority in every state:
  - pc<=redirect_pc, if_valid<=0, hold buffer invalidated;
  - next state is DRAIN if a request is outstanding (WAIT, or DRAIN without its response yet), otherwise ISSUE.
  - A redirect in the same cycle as imem_valid in WAIT discards that response and goes to ISSUE, not DRAIN.
  - Redirect while stall=1 still flushes the slot.
- Only one request is ever outstanding. imem_valid outside WAIT/DRAIN is ignored.
- The memory interface is in-order with response latency ≥1 cycle.
- PC arithmetic is modulo 2^PC_WIDTH: 16'hFFFF+1 = 16'h0000, no flag.
- if_instr, if_pc and if_pc_next are stable whenever if_valid=1 and stall=1.
- Latency with 1-cycle memory:
  - imem_req=1, addr=RESET_PC in the first cycle after reset deasserts;
  - if_valid=1 two edges later;
  - steady state is 1 instruction per 2 cycles.

Test Plan:
- Reset release, memory returns 32'h2002_0005 one cycle after each request -> imem_addr sequence 0,1,2...; first if_valid=1 with if_pc=0, if_instr=32'h2002_0005, if_pc_next=1; one instruction every 2 cycles.
- stall=1 for 5 cycles while the slot is valid and the next response arrives -> slot unchanged, FSM in HOLD, no imem_req; after stall drops, next slot has the buffered instruction and if_pc = previous+1; no instruction lost or duplicated.
- redirect_valid with redirect_pc=16'h0040 while WAIT and 3-cycle memory latency -> the stale response is dropped, the next imem_addr is 16'h0040, and the next if_pc is 16'h0040.
- redirect in the ISSUE cycle -> no imem_req that cycle; next cycle imem_req=1 with imem_addr=redirect_pc; if_valid=0.
- Redirect to 16'hFFFF -> if_pc=16'hFFFF with if_pc_next=16'h0000, followed by a fetch at 16'h0000.
- reset asserted mid-WAIT, late imem_valid arrives after release -> outputs return to 0 immediately; the stale response does not corrupt the slot (bench holds imem_valid low until the first post-reset request).

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : one-cycle request strobe (fetch -> memory)
//   imem_addr  : word address, meaningful while imem_req=1
//   imem_valid : response strobe, imem_data valid this cycle (memory -> fetch)
//   imem_data  : returned instruction word
// Handshake: a request is accepted on any clock edge where imem_req=1 (no
// ready); the memory answers in order with exactly one imem_valid pulse per
// request, at least one cycle later. The fetch stage keeps one request open.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_valid;
  logic [INSTR_WIDTH-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the program counter, issues one request at a
// time over the imem bus, and presents each returned instruction with its PC
// in the IF/ID register consumed by decode.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   mem             : instruction-memory bus (master side)
//   stall           : decode cannot accept; IF/ID register holds
//   redirect_valid  : taken branch/jump, restart fetch at redirect_pc
//   redirect_pc     : redirect target
//   if_valid/if_instr/if_pc/if_pc_next : IF/ID register contents
//   dbg_state       : FSM state (0 ISSUE, 1 WAIT, 2 HOLD, 3 DRAIN)
module fetch_stage #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_stage_if.master          mem,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [PC_WIDTH-1:0]    if_pc_next,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic                   hold_valid;
  logic [INSTR_WIDTH-1:0] hold_instr;
  logic [PC_WIDTH-1:0]    hold_pc;

  // A redirect suppresses the request in the same cycle, so the stale pc is
  // never sent to memory.
  assign mem.imem_req  = !reset && (state == ISSUE) && !redirect_valid;
  assign mem.imem_addr = pc;
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ISSUE;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc_next <= '0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc;
      if_valid   <= 1'b0;
      hold_valid <= 1'b0;
      // A response that lands in this same cycle is dropped here, so DRAIN is
      // only needed while the outstanding response is still to come.
      if ((state == WAIT || state == DRAIN) && !mem.imem_valid) begin
        state <= DRAIN;
      end else begin
        state <= ISSUE;
      end
    end else begin
      // Decode takes the slot on any non-stalled edge; a load below wins.
      if (if_valid && !stall) begin
        if_valid <= 1'b0;
      end
      case (state)
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mem.imem_valid) begin
            pc <= pc + 1'b1;
            if (!if_valid || !stall) begin
              if_valid   <= 1'b1;
              if_instr   <= mem.imem_data;
              if_pc      <= pc;
              if_pc_next <= pc + 1'b1;
              state      <= ISSUE;
            end else begin
              hold_valid <= 1'b1;
              hold_instr <= mem.imem_data;
              hold_pc    <= pc;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid   <= hold_valid;
            if_instr   <= hold_instr;
            if_pc      <= hold_pc;
            if_pc_next <= hold_pc + 1'b1;
            hold_valid <= 1'b0;
            state      <= ISSUE;
          end
        end
        DRAIN: begin
          if (mem.imem_valid) begin
            state <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule
